// File: rtl/dvs_ravens_queue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dvs_ravens_queue_sched: single-port FIFO access scheduler, DVS writer    |
// | (M1) vs Ravens reader (M2), with a bounded writer streak. Rev 1.0        |
// +--------------------------------------------------------------------------+
module dvs_ravens_queue_sched #(
  parameter int  DEPTH         = 16,
  parameter int  MAX_WR_STREAK = 4,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_m1,
  input  logic              req_m2,
  output logic              grant_m1,
  output logic              grant_m2,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rd_data_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count
);

  localparam int                c_STREAK_W   = $clog2(MAX_WR_STREAK + 1);
  localparam logic [ADDR_W:0]   c_DEPTH_CNT  = DEPTH[ADDR_W:0];
  localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = MAX_WR_STREAK[c_STREAK_W-1:0];

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [c_STREAK_W-1:0] streak_q, streak_d;
  logic                  rd_valid_q;

  logic w_wr_ok;
  logic w_rd_ok;
  logic w_force_rd;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == c_DEPTH_CNT);
  assign fifo_count = count_q;

  assign w_wr_ok    = req_m1 & ~fifo_full;
  assign w_rd_ok    = req_m2 & ~fifo_empty;
  assign w_force_rd = (streak_q == c_MAX_STREAK);

  // Writer wins contention until its streak hits the limit; reset masks both.
  assign grant_m1 = ~rst & w_wr_ok & ~(w_rd_ok & w_force_rd);
  assign grant_m2 = ~rst & w_rd_ok & (~w_wr_ok | w_force_rd);

  assign mem_we        = grant_m1;
  assign mem_re        = grant_m2;
  assign mem_addr      = grant_m1 ? wr_ptr_q : rd_ptr_q;
  assign rd_data_valid = rd_valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    streak_d = streak_q;
    if (grant_m1) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      count_d  = count_q + (ADDR_W+1)'(1);
    end
    if (grant_m2) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d  = count_q - (ADDR_W+1)'(1);
    end
    // Streak only counts writer wins that actually denied a ready reader.
    if (grant_m2 || !w_rd_ok) begin
      streak_d = '0;
    end else if (grant_m1 && (streak_q != c_MAX_STREAK)) begin
      streak_d = streak_q + c_STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      streak_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      streak_q   <= streak_d;
      rd_valid_q <= grant_m2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvs_ravens_queue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dvs_ravens_queue_sched: directed and randomized checks of the FIFO    |
// | access scheduler against a queue-based reference model. Rev 1.0          |
// +--------------------------------------------------------------------------+
module tb_dvs_ravens_queue_sched;

  localparam int D  = 4;
  localparam int MS = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_m1 = 1'b0;
  logic          req_m2 = 1'b0;
  logic          grant_m1, grant_m2, mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic          rd_data_valid, fifo_empty, fifo_full;
  logic [AW:0]   fifo_count;

  dvs_ravens_queue_sched #(.DEPTH(D), .MAX_WR_STREAK(MS)) dut (
    .clk(clk), .rst(rst), .req_m1(req_m1), .req_m2(req_m2),
    .grant_m1(grant_m1), .grant_m2(grant_m2), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .rd_data_valid(rd_data_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of slot indices holding events, plus read slot.
  int m_q[$];
  int m_rd = 0;
  int m_streak = 0;
  bit m_rdv = 1'b0;
  bit in_r1, in_r2, in_rst;
  bit e_g1, e_g2, e_rdok;
  int e_addr;

  logic [11:0] obs;
  assign obs = {grant_m1, grant_m2, mem_we, mem_re, mem_addr, rd_data_valid,
                fifo_empty, fifo_full, fifo_count};

  function automatic void model_eval();
    int  cnt   = m_q.size();
    bit  wr_ok = in_r1 && (cnt < D);
    e_rdok = in_r2 && (cnt > 0);
    if (in_rst) begin
      e_g1 = 0; e_g2 = 0;
    end else if (wr_ok && e_rdok) begin
      e_g2 = (m_streak == MS);
      e_g1 = !e_g2;
    end else begin
      e_g1 = wr_ok; e_g2 = e_rdok;
    end
    if (e_g1)      e_addr = (m_rd + cnt) % D;
    else if (e_g2) e_addr = m_q[0];
    else           e_addr = m_rd;
  endfunction

  function automatic void model_commit();
    if (in_rst) begin
      m_q.delete(); m_rd = 0; m_streak = 0; m_rdv = 0;
    end else begin
      m_rdv = e_g2;
      if (e_g1) m_q.push_back((m_rd + m_q.size()) % D);
      if (e_g2) begin
        void'(m_q.pop_front());
        m_rd = (m_rd + 1) % D;
      end
      if (e_g2 || !e_rdok) m_streak = 0;
      else if (e_g1)       m_streak = (m_streak + 1 > MS) ? MS : m_streak + 1;
    end
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [AW-1:0] a = AW'(e_addr);
    logic [AW:0]   c = (AW+1)'(m_q.size());
    return {e_g1, e_g2, e_g1, e_g2, a, m_rdv, m_q.size() == 0, m_q.size() == D, c};
  endfunction

  // Called one time unit after a rising edge; leaves outputs settled mid-cycle.
  task automatic drive(input bit r1, input bit r2, input bit rs);
    req_m1 = r1; req_m2 = r2; rst = rs;
    in_r1 = r1; in_r2 = r2; in_rst = rs;
    #2;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1);
      n_cmp++;
      if ({grant_m1, grant_m2, mem_we, mem_re} !== 4'b0000) begin
        n_bad++; $display("FAIL reset_grants cyc%0d got=%b want=0000", i, {grant_m1, grant_m2, mem_we, mem_re});
      end
      advance();
    end
    drive(0, 0, 0);
    n_cmp++;
    if ({fifo_empty, fifo_full, fifo_count, mem_addr} !== {1'b1, 1'b0, 3'd0, 2'd0}) begin
      n_bad++; $display("FAIL reset_state got e=%b f=%b c=%0d a=%0d want e=1 f=0 c=0 a=0",
                        fifo_empty, fifo_full, fifo_count, mem_addr);
    end
    advance();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0);
      n_cmp++;
      if (grant_m1 !== (i < 4) || grant_m2 !== 1'b0) begin
        n_bad++; $display("FAIL fill_grant cyc%0d got g1=%b g2=%b want g1=%b g2=0", i, grant_m1, grant_m2, i < 4);
      end
      if (i < 4) begin
        n_cmp++;
        if (mem_addr !== AW'(i)) begin
          n_bad++; $display("FAIL fill_addr cyc%0d got=%0d want=%0d", i, mem_addr, i);
        end
      end
      advance();
    end
    drive(0, 0, 0);
    n_cmp++;
    if (fifo_full !== 1'b1 || fifo_count !== 3'd4) begin
      n_bad++; $display("FAIL fill_full got f=%b c=%0d want f=1 c=4", fifo_full, fifo_count);
    end
    advance();
  endtask

  task automatic test_drain_wrap();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0);
      n_cmp++;
      if (grant_m2 !== 1'b1 || mem_addr !== AW'(i)) begin
        n_bad++; $display("FAIL drain_first cyc%0d got g2=%b a=%0d want g2=1 a=%0d", i, grant_m2, mem_addr, i);
      end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0);
      n_cmp++;
      if (grant_m1 !== 1'b1 || mem_addr !== AW'(i)) begin
        n_bad++; $display("FAIL wrap_write cyc%0d got g1=%b a=%0d want g1=1 a=%0d", i, grant_m1, mem_addr, i);
      end
      advance();
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0);
      n_cmp++;
      if (grant_m2 !== (i < 2) || rd_data_valid !== (i == 1 || i == 2) ||
          (i < 2 && mem_addr !== AW'(i))) begin
        n_bad++; $display("FAIL wrap_read cyc%0d got g2=%b v=%b a=%0d want g2=%b v=%b a=%0d",
                          i, grant_m2, rd_data_valid, mem_addr, i < 2, (i == 1 || i == 2), i);
      end
      advance();
    end
    drive(0, 0, 0);
    n_cmp++;
    if (fifo_empty !== 1'b1 || rd_data_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap_empty got e=%b v=%b want e=1 v=0", fifo_empty, rd_data_valid);
    end
    advance();
  endtask

  task automatic test_streak();
    int pat[6] = '{1, 1, 2, 1, 1, 2};
    int got;
    drive(1, 0, 0);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0);
      got = grant_m1 ? 1 : (grant_m2 ? 2 : 0);
      n_cmp++;
      if (got !== pat[i] || (grant_m1 & grant_m2)) begin
        n_bad++; $display("FAIL streak_pattern cyc%0d got M%0d want M%0d", i, got, pat[i]);
      end
      advance();
    end
  endtask

  task automatic test_full_contention();
    drive(1, 0, 0);
    advance();
    drive(1, 1, 0);
    n_cmp++;
    if (fifo_full !== 1'b1 || grant_m2 !== 1'b1 || grant_m1 !== 1'b0) begin
      n_bad++; $display("FAIL full_contend got f=%b g1=%b g2=%b want f=1 g1=0 g2=1", fifo_full, grant_m1, grant_m2);
    end
    advance();
    drive(1, 1, 0);
    n_cmp++;
    if (fifo_count !== 3'd3 || grant_m1 !== 1'b1) begin
      n_bad++; $display("FAIL full_after got c=%0d g1=%b want c=3 g1=1", fifo_count, grant_m1);
    end
    advance();
    drive(0, 1, 0);
    advance();
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 1);
    n_cmp++;
    if (grant_m1 !== 1'b0 || grant_m2 !== 1'b0 || fifo_count !== 3'd3) begin
      n_bad++; $display("FAIL midreset_grant got g1=%b g2=%b c=%0d want g1=0 g2=0 c=3", grant_m1, grant_m2, fifo_count);
    end
    advance();
    drive(0, 0, 0);
    n_cmp++;
    if (fifo_empty !== 1'b1 || rd_data_valid !== 1'b0 || mem_addr !== 2'd0 || fifo_count !== 3'd0) begin
      n_bad++; $display("FAIL midreset_state got e=%b v=%b a=%0d c=%0d want e=1 v=0 a=0 c=0",
                        fifo_empty, rd_data_valid, mem_addr, fifo_count);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, $urandom_range(0, 63) == 0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++; $display("FAIL random cyc%0d got=%b want=%b", i, obs, exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    in_rst = 1'b1;
    @(posedge clk);
    model_commit();
    #1;
    test_reset();
    test_fill();
    test_drain_wrap();
    test_streak();
    test_full_contention();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
